tcb_peri_gpio_mbank: RTL
========================

# tcb_peri_gpio_mbank

Multi-bank GPIO controller core with per-pin glitch filter and configurable edge/level interrupts; next-generation replacement for the single-bank GPIO core. It sits behind a TCB-variant adapter (the TCB-Lite wrapper maps `sub.req`/`sub.rsp` onto the `sys_*` ports) and drives pads plus one interrupt request to the system interrupt controller.

## Interface
- `GPIO_DAT`, 32: pins per bank
- `GPIO_BNK`, 2: number of banks, 1..16
- `GPIO_CDC`, 2: input synchronizer stages (0 = bypass)
- `FLT_DIV`, 1: filter sample period in clock cycles, >=1
- `FLT_LEN`, 1: consecutive equal samples needed to accept a new level (1 = no filter)
- `SYS_DAT`, 32: system data width, >= `GPIO_DAT`
- `ADR_W`, derived `3+$clog2(GPIO_BNK)`: word address width
- `clk  in  1  system clock`
- `rst  in  1  reset; asynchronous, active-high`
- `gpio_o  out  GPIO_BNK*GPIO_DAT  output values`
- `gpio_e  out  GPIO_BNK*GPIO_DAT  output enables`
- `gpio_i  in  GPIO_BNK*GPIO_DAT  pad inputs (async)`
- `sys_wen  in  1  write strobe`; `sys_wad  in  ADR_W  write word address`; `sys_wdt  in  SYS_DAT  write data`
- `sys_ren  in  1  read strobe`; `sys_rad  in  ADR_W  read word address`; `sys_rdt  out  SYS_DAT  read data`
- `irq_bnk  out  GPIO_BNK  per-bank interrupt`
- `irq  out  1  OR of `irq_bnk``

## Operation
- Address = {bank, reg[2:0]}; bank >= `GPIO_BNK`: writes ignored, reads return 0.
- Registers per bank: 0 OUT (rw), 1 OEN (rw), 2 IN (ro, filtered), 3 ENA (rw), 4 LVL (rw, 1=level, 0=edge), 5 POL (rw, 1=rising/high, 0=falling/low), 6 BTH (rw, edge mode: 1=both edges, overrides POL), 7 STS (read; write-1-to-clear).
- Input path: `GPIO_CDC` FF stages, then filter. Global prescaler counts 0..`FLT_DIV`-1 and emits `tick` at wrap. Per pin: on `tick`, if sample == IN bit, clear counter; else increment; at `FLT_LEN`-1 load IN with sample and clear counter.
- Event per pin from IN and IN_prev (IN delayed one cycle): edge rise = IN&~prev, fall = ~IN&prev; level = (IN==POL).
- STS bit set when ENA & event; set has priority over a same-cycle W1C. Level mode: STS re-sets every cycle condition holds, so clearing only sticks after the condition ends.
- ENA=0 blocks new sets; existing STS bits remain readable/clearable.
- `irq_bnk[b]` = |(STS[b] & ENA[b]); `irq` = |`irq_bnk`.
- Write data bits above `GPIO_DAT` ignored; reads zero-extend.

## Timing
- Reset: all registers, synchronizer, filter counters, prescaler, IN, IN_prev = 0; `gpio_o`=`gpio_e`=0; `irq`=`irq_bnk`=0. Reset mid-filter discards partial counts.
- Writes take effect on the edge ending the `sys_wen` cycle; `gpio_o`/`gpio_e` change next cycle.
- `sys_rdt` combinational from `sys_rad` when `sys_ren`=1, else 0 (zero-latency, no backpressure). Reads have no side effects.
- Same-cycle read and write of one register: read returns the old value.
- Input latency, `FLT_DIV`=1, `FLT_LEN`=1: `gpio_i` change visible in IN after `GPIO_CDC`+1 cycles; STS and `irq` one cycle later.
- Prescaler and filter counters wrap freely; no overflow state.

## Structure
- Package `tcb_peri_gpio_pkg`: register offset localparams (`GPIO_OUT`..`GPIO_STS`) and mode encoding constants; shared with the TCB-Lite wrapper and the bench.
- Sub-module `tcb_peri_gpio_flt`: one bank's synchronizer plus filter, `GPIO_DAT` wide, shared `tick` input; instantiated `GPIO_BNK` times in a generate loop. Registers and interrupt logic stay in the top.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; read every register of both banks -> 0.
- Output: write bank1 OUT=0xA5A5_0000, OEN=0xFFFF_0000 -> `gpio_o[63:32]`=0xA5A5_0000, `gpio_e[63:32]`=0xFFFF_0000 next cycle; bank0 unchanged.
- Filter: `FLT_DIV`=4, `FLT_LEN`=3; glitch on pin 0 for 5 cycles -> IN stays 0; hold high 20 cycles -> IN bit0 = 1 within `GPIO_CDC`+12+1 cycles.
- Edge IRQ: bank0 ENA=1, POL=1, BTH=0; raise then lower pin 0 -> STS=1 and `irq`=1 after rise only; write STS=1 -> `irq`=0; with BTH=1 both edges set STS.
- Level IRQ plus priority: LVL=1, POL=0, pin low -> W1C leaves STS=1; raise pin, W1C -> STS=0; rising-edge event in same cycle as W1C -> STS stays 1.
- Out-of-range bank (`GPIO_BNK`=3, bank 3 access): write ignored, read returns 0.

Source files
------------

// File: rtl/tcb_peri_gpio_pkg.sv
// Shared definitions for the multi-bank GPIO core: register offsets and
// per-bit mode encodings used by the core, its bus wrapper and the bench.
package tcb_peri_gpio_pkg;

  // Register offsets within one bank (low three word-address bits).
  typedef enum logic [2:0] {
    GPIO_OUT = 3'd0,
    GPIO_OEN = 3'd1,
    GPIO_IN  = 3'd2,
    GPIO_ENA = 3'd3,
    GPIO_LVL = 3'd4,
    GPIO_POL = 3'd5,
    GPIO_BTH = 3'd6,
    GPIO_STS = 3'd7
  } gpio_reg_t;

  // Per-bit LVL encoding.
  typedef enum logic {
    MODE_EDGE  = 1'b0,
    MODE_LEVEL = 1'b1
  } gpio_mode_t;

  // Per-bit POL encoding.
  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } gpio_pol_t;

  // Per-bit BTH encoding (edge mode only).
  typedef enum logic {
    BTH_ONE  = 1'b0,
    BTH_BOTH = 1'b1
  } gpio_bth_t;

endpackage

// File: rtl/tcb_peri_gpio_flt.sv
// One bank of pad inputs: optional synchronizer chain followed by a
// per-pin glitch filter clocked by a shared sample tick.
module tcb_peri_gpio_flt #(
  parameter int unsigned GPIO_DAT = 32,
  parameter int unsigned GPIO_CDC = 2,
  parameter int unsigned FLT_LEN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [GPIO_DAT-1:0] gpio_i,
  output logic [GPIO_DAT-1:0] gpio_f
);

  localparam int unsigned CNT_W = (FLT_LEN > 1) ? $clog2(FLT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FLT_LEN - 1);

  logic [GPIO_DAT-1:0] smp;
  logic [CNT_W-1:0]    cnt [GPIO_DAT];

  generate
    if (GPIO_CDC == 0) begin : g_bypass
      assign smp = gpio_i;
    end else begin : g_sync
      logic [GPIO_DAT-1:0] sync [GPIO_CDC];

      // Synchronizer shift chain for the asynchronous pad inputs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < GPIO_CDC; i++) sync[i] <= '0;
        end else begin
          sync[0] <= gpio_i;
          for (int unsigned i = 1; i < GPIO_CDC; i++) sync[i] <= sync[i-1];
        end
      end

      assign smp = sync[GPIO_CDC-1];
    end
  endgenerate

  // A pin's filtered level changes only after FLT_LEN consecutive ticks
  // see the same differing sample; any matching sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_f <= '0;
      for (int unsigned i = 0; i < GPIO_DAT; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < GPIO_DAT; i++) begin
        if (smp[i] == gpio_f[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_END) begin
          gpio_f[i] <= smp[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tcb_peri_gpio_mbank.sv
// Multi-bank GPIO core: per-bank output/enable registers, filtered inputs,
// and edge/level interrupt status with write-1-to-clear.
module tcb_peri_gpio_mbank
  import tcb_peri_gpio_pkg::*;
#(
  parameter int unsigned GPIO_DAT = 32,
  parameter int unsigned GPIO_BNK = 2,
  parameter int unsigned GPIO_CDC = 2,
  parameter int unsigned FLT_DIV  = 1,
  parameter int unsigned FLT_LEN  = 1,
  parameter int unsigned SYS_DAT  = 32,
  parameter int unsigned ADR_W    = 3 + $clog2(GPIO_BNK)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [GPIO_BNK*GPIO_DAT-1:0] gpio_o,
  output logic [GPIO_BNK*GPIO_DAT-1:0] gpio_e,
  input  logic [GPIO_BNK*GPIO_DAT-1:0] gpio_i,
  input  logic                         sys_wen,
  input  logic [ADR_W-1:0]             sys_wad,
  input  logic [SYS_DAT-1:0]           sys_wdt,
  input  logic                         sys_ren,
  input  logic [ADR_W-1:0]             sys_rad,
  output logic [SYS_DAT-1:0]           sys_rdt,
  output logic [GPIO_BNK-1:0]          irq_bnk,
  output logic                         irq
);

  localparam int unsigned BNK_W = (GPIO_BNK > 1) ? $clog2(GPIO_BNK) : 1;
  localparam int unsigned DIV_W = (FLT_DIV > 1) ? $clog2(FLT_DIV) : 1;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;

  logic [GPIO_DAT-1:0] reg_out  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_oen  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_ena  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_lvl  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_pol  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_bth  [GPIO_BNK];
  logic [GPIO_DAT-1:0] reg_sts  [GPIO_BNK];
  logic [GPIO_DAT-1:0] pin_in   [GPIO_BNK];
  logic [GPIO_DAT-1:0] pin_prev [GPIO_BNK];
  logic [GPIO_DAT-1:0] evt      [GPIO_BNK];
  logic [GPIO_DAT-1:0] clr      [GPIO_BNK];
  logic [GPIO_BNK-1:0] wsel;

  logic [BNK_W-1:0]    wbank;
  logic [BNK_W-1:0]    rbank;
  gpio_reg_t           wreg;
  gpio_reg_t           rreg;
  logic [GPIO_DAT-1:0] wdat;
  logic [GPIO_DAT-1:0] rdat;
  logic                unused_wdt;

  generate
    if (GPIO_BNK > 1) begin : g_bank_adr
      assign wbank = sys_wad[ADR_W-1:3];
      assign rbank = sys_rad[ADR_W-1:3];
    end else begin : g_single_adr
      assign wbank = '0;
      assign rbank = '0;
    end
  endgenerate

  assign wreg       = gpio_reg_t'(sys_wad[2:0]);
  assign rreg       = gpio_reg_t'(sys_rad[2:0]);
  assign wdat       = sys_wdt[GPIO_DAT-1:0];
  assign unused_wdt = ^sys_wdt;

  // Global filter prescaler; tick marks the wrap back to zero.
  assign tick = (div_cnt == DIV_W'(FLT_DIV - 1));

  // Prescaler counter, free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  generate
    for (genvar b = 0; b < GPIO_BNK; b++) begin : g_bank
      tcb_peri_gpio_flt #(
        .GPIO_DAT (GPIO_DAT),
        .GPIO_CDC (GPIO_CDC),
        .FLT_LEN  (FLT_LEN)
      ) u_flt (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .gpio_i (gpio_i[b*GPIO_DAT +: GPIO_DAT]),
        .gpio_f (pin_in[b])
      );

      assign gpio_o[b*GPIO_DAT +: GPIO_DAT] = reg_out[b];
      assign gpio_e[b*GPIO_DAT +: GPIO_DAT] = reg_oen[b];
      assign irq_bnk[b] = |(reg_sts[b] & reg_ena[b]);
    end
  endgenerate

  assign irq = |irq_bnk;

  // Bank write select and W1C mask; banks beyond GPIO_BNK never match.
  always_comb begin
    wsel = '0;
    for (int unsigned b = 0; b < GPIO_BNK; b++) begin
      clr[b]  = '0;
      wsel[b] = sys_wen && (wbank == BNK_W'(b));
      if (wsel[b] && (wreg == GPIO_STS)) clr[b] = wdat;
    end
  end

  // Per-pin interrupt event from the filtered level and its one-cycle delay.
  always_comb begin
    for (int unsigned b = 0; b < GPIO_BNK; b++) begin
      evt[b] = '0;
      for (int unsigned i = 0; i < GPIO_DAT; i++) begin
        if (reg_lvl[b][i] == MODE_LEVEL)
          evt[b][i] = (pin_in[b][i] == reg_pol[b][i]);
        else if (reg_bth[b][i] == BTH_BOTH)
          evt[b][i] = pin_in[b][i] ^ pin_prev[b][i];
        else if (reg_pol[b][i] == POL_HIGH)
          evt[b][i] = pin_in[b][i] & ~pin_prev[b][i];
        else
          evt[b][i] = ~pin_in[b][i] & pin_prev[b][i];
      end
    end
  end

  // Register file updates; a status set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < GPIO_BNK; b++) begin
        reg_out[b]  <= '0;
        reg_oen[b]  <= '0;
        reg_ena[b]  <= '0;
        reg_lvl[b]  <= '0;
        reg_pol[b]  <= '0;
        reg_bth[b]  <= '0;
        reg_sts[b]  <= '0;
        pin_prev[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < GPIO_BNK; b++) begin
        pin_prev[b] <= pin_in[b];
        reg_sts[b]  <= (reg_sts[b] & ~clr[b]) | (reg_ena[b] & evt[b]);
        if (wsel[b]) begin
          case (wreg)
            GPIO_OUT: reg_out[b] <= wdat;
            GPIO_OEN: reg_oen[b] <= wdat;
            GPIO_ENA: reg_ena[b] <= wdat;
            GPIO_LVL: reg_lvl[b] <= wdat;
            GPIO_POL: reg_pol[b] <= wdat;
            GPIO_BTH: reg_bth[b] <= wdat;
            default:  ;
          endcase
        end
      end
    end
  end

  // Zero-latency read mux; unmapped banks and idle cycles read as zero.
  always_comb begin
    rdat = '0;
    for (int unsigned b = 0; b < GPIO_BNK; b++) begin
      if (sys_ren && (rbank == BNK_W'(b))) begin
        case (rreg)
          GPIO_OUT: rdat = reg_out[b];
          GPIO_OEN: rdat = reg_oen[b];
          GPIO_IN:  rdat = pin_in[b];
          GPIO_ENA: rdat = reg_ena[b];
          GPIO_LVL: rdat = reg_lvl[b];
          GPIO_POL: rdat = reg_pol[b];
          GPIO_BTH: rdat = reg_bth[b];
          GPIO_STS: rdat = reg_sts[b];
          default:  rdat = '0;
        endcase
      end
    end
  end

  assign sys_rdt = SYS_DAT'(rdat);

endmodule
